// File: rtl/encoder_4x2_debounced_pkg.sv
// Shared constants, output-side state encoding and pattern helpers for the
// 4-to-2 debounced encoder; the line/code widths match the 2x4 decoder family.
package encoder_4x2_debounced_pkg;

    localparam int LINE_W           = 4;
    localparam int CODE_W           = 2;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } out_state_t;

    // Highest set line wins; an all-zero pattern maps to 0.
    function automatic logic [CODE_W-1:0] priority_code(input logic [LINE_W-1:0] pattern);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < LINE_W; i++) begin
            if (pattern[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

    function automatic logic more_than_one(input logic [LINE_W-1:0] pattern);
        return (pattern & (pattern - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/encoder_4x2_debounced_if.sv
// Output-side bus of the debounced encoder: code, valid/ready handshake and status flags.
interface encoder_4x2_debounced_if;
    import encoder_4x2_debounced_pkg::*;

    logic [CODE_W-1:0] b;
    logic              valid;
    logic              ready;
    logic              any;
    logic              multi;
    logic              overrun;

    modport master (
        output b, valid, any, multi, overrun,
        input  ready
    );

    modport slave (
        input  b, valid, any, multi, overrun,
        output ready
    );

endinterface

// File: rtl/encoder_4x2_debounced_debounce_vec.sv
// Two-flop synchroniser plus a shared-counter vector debouncer; upd flags the
// edge on which a newly settled pattern is written into stable.
module debounce_vec #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] pattern,
    output logic             upd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    // Combinational so the top can load its code on the same edge stable moves.
    assign upd     = (sync2 == cand) && (cnt >= CNT_LAST) && (cand != stable);
    assign pattern = cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else if (cand != stable) begin
                stable <= cand;
            end
        end
    end

endmodule

// File: rtl/encoder_4x2_debounced.sv
// Debounced 4-to-2 priority encoder: each newly stable non-zero pattern is
// issued once as a code over a valid/ready handshake, with a sticky overrun flag.
module encoder_4x2_debounced
    import encoder_4x2_debounced_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LINE_W-1:0]        a,
    encoder_4x2_debounced_if.master  bus
);

    logic [LINE_W-1:0] stable;
    logic [LINE_W-1:0] pattern;
    logic              upd;
    logic              event_nz;
    out_state_t        state;
    logic [CODE_W-1:0] code_q;
    logic              overrun_q;

    debounce_vec #(
        .WIDTH           (LINE_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .raw     (a),
        .stable  (stable),
        .pattern (pattern),
        .upd     (upd)
    );

    // Releases settle into stable but never produce a code.
    assign event_nz = upd && (pattern != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            code_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (event_nz) begin
                        code_q <= priority_code(pattern);
                        state  <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (event_nz) begin
                        // Accept on the same edge frees the slot for the new code.
                        if (bus.ready) code_q    <= priority_code(pattern);
                        else           overrun_q <= 1'b1;
                    end else if (bus.ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.b       = code_q;
    assign bus.valid   = (state == ST_FULL);
    assign bus.overrun = overrun_q;
    assign bus.any     = |stable;
    assign bus.multi   = more_than_one(stable);

endmodule
